// File: rtl/fp_booth_seq_mul_if.sv
// Operand/product handshake bundle for fp_booth_seq_mul.
// master = upstream driver / downstream consumer side, slave = the multiplier.
interface fp_booth_seq_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] frc_X;
  logic [22:0] frc_Y;
  logic        x_sub;
  logic        y_sub;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] frc_Z_full;
  logic        norm_n;

  modport master (
    output in_valid, frc_X, frc_Y, x_sub, y_sub, out_ready,
    input  in_ready, out_valid, frc_Z_full, norm_n
  );

  modport slave (
    input  in_valid, frc_X, frc_Y, x_sub, y_sub, out_ready,
    output in_ready, out_valid, frc_Z_full, norm_n
  );
endinterface

// File: rtl/fp_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier for 24-bit FP significands (13 CALC cycles).
// Optional macro FP_MUL_ZERO_BYPASS_EN: subnormal/zero operands skip CALC and go straight to DONE.
module fp_booth_seq_mul (
  input  logic               clk,
  input  logic               rst,
  fp_booth_seq_mul_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nxt;
  logic        [3:0]     cnt;
  logic signed [49:0]    mx_sh;
  logic        [26:0]    my_sh;
  logic signed [49:0]    acc;
  logic signed [49:0]    acc_nxt;
  logic                  accept;
  logic                  op_sub;

  function automatic logic signed [49:0] booth_pp(input logic [2:0] dig,
                                                  input logic signed [49:0] m);
    logic signed [49:0] pp;
    case (dig)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m <<< 1;
      3'b100:         pp = -(m <<< 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  assign accept  = (state == IDLE) && bus.in_valid;
  assign op_sub  = bus.x_sub | bus.y_sub;
  assign acc_nxt = acc + booth_pp(my_sh[2:0], mx_sh);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef FP_MUL_ZERO_BYPASS_EN
          state_nxt = op_sub ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == 4'd12) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = ~rst;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch on accept, one Booth digit per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      acc            <= '0;
      mx_sh          <= '0;
      my_sh          <= '0;
      bus.frc_Z_full <= '0;
      bus.norm_n     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // A flushed operand zeroes the multiplicand so the product is exactly 0.
            mx_sh <= op_sub ? 50'sd0 : $signed({26'd0, 1'b1, bus.frc_X});
            my_sh <= {2'b00, ~bus.y_sub, bus.frc_Y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
`ifdef FP_MUL_ZERO_BYPASS_EN
            if (op_sub) begin
              bus.frc_Z_full <= '0;
              bus.norm_n     <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          mx_sh <= mx_sh <<< 2;
          my_sh <= my_sh >> 2;
          if (cnt == 4'd12) begin
            cnt            <= '0;
            bus.frc_Z_full <= acc_nxt[47:0];
            bus.norm_n     <= acc_nxt[47];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
